// File: rtl/popcount_stream_pkg.sv
// Shared types and helpers for the popcount stream: half-word counter type,
// S1 payload struct, generic popcount and count-width helper.
package popcount_stream_pkg;

  localparam int unsigned MAX_W  = 64;
  localparam int unsigned HCNT_W = 7;

  typedef logic [HCNT_W-1:0] hcnt_t;

  typedef struct packed {
    hcnt_t lo;
    hcnt_t hi;
    logic  last;
  } s1_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Callers zero-extend narrower words to MAX_W.
  function automatic hcnt_t popcount(input logic [MAX_W-1:0] v);
    hcnt_t c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + HCNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// Input word handshake and result handshake of the popcount stream.
interface popcount_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 12
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [WIDTH:0]   out_onehot;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_onehot, out_sum, out_sat, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_onehot, out_sum, out_sat, out_last
  );
endinterface

// File: rtl/popcount_stream_half.sv
// Combinational popcount of one half of the input word.
module popcount_stream_half
  import popcount_stream_pkg::*;
#(
  parameter int unsigned HW = 4
) (
  input  logic [HW-1:0] data,
  output hcnt_t         cnt
);

  assign cnt = popcount(MAX_W'(data));

endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming popcount: S1 counts word halves, S2 sums them and keeps
// a saturating per-frame running sum. S2 registers drive the outputs.
module popcount_stream
  import popcount_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 12
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clr,
  popcount_stream_if.slave  bus
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned RAW_W = ACC_W + 1;
  localparam int unsigned OH_W  = WIDTH + 1;

  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic [CNT_W-1:0] cnt_q;
  logic [OH_W-1:0]  onehot_q;
  logic [ACC_W-1:0] sum_q;
  logic             sat_q;
  logic             last_q;
  logic             frame_start;

  hcnt_t            lo_c;
  hcnt_t            hi_c;
  logic             en1_c;
  logic             en2_c;
  logic             take_c;
  logic [CNT_W-1:0] cnt_c;
  logic [ACC_W-1:0] base_c;
  logic [RAW_W-1:0] raw_c;
  logic [ACC_W-1:0] sum_c;
  logic             sat_c;
  logic [OH_W-1:0]  onehot_c;

  popcount_stream_half #(.HW(HALF)) u_lo (.data(bus.in_data[HALF-1:0]),     .cnt(lo_c));
  popcount_stream_half #(.HW(HALF)) u_hi (.data(bus.in_data[WIDTH-1:HALF]), .cnt(hi_c));

  // Pipeline enables; in_ready never depends on in_valid.
  assign en2_c        = !s2_valid | bus.out_ready;
  assign en1_c        = !s1_valid | en2_c;
  assign bus.in_ready = en1_c & !clr;
  assign take_c       = bus.in_valid & bus.in_ready;

  // S2 next values: combined count, frame sum with saturation, one-hot decode.
  always_comb begin
    cnt_c    = CNT_W'(s1_q.lo + s1_q.hi);
    base_c   = frame_start ? '0 : sum_q;
    raw_c    = RAW_W'(base_c) + RAW_W'(cnt_c);
    sum_c    = raw_c[ACC_W] ? '1 : raw_c[ACC_W-1:0];
    sat_c    = (!frame_start & sat_q) | raw_c[ACC_W];
    onehot_c = OH_W'(1) << cnt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      cnt_q       <= '0;
      onehot_q    <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      last_q      <= 1'b0;
      frame_start <= 1'b1;
    end else if (clr) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      if (en1_c) begin
        s1_valid <= take_c;
        if (take_c) begin
          s1_q <= '{lo: lo_c, hi: hi_c, last: bus.in_last};
        end
      end
      // A bubble leaves the frame state untouched.
      if (en2_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          cnt_q       <= cnt_c;
          onehot_q    <= onehot_c;
          sum_q       <= sum_c;
          sat_q       <= sat_c;
          last_q      <= s1_q.last;
          frame_start <= s1_q.last;
        end
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_count  = cnt_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_sum    = sum_q;
  assign bus.out_sat    = sat_q;
  assign bus.out_last   = last_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Scoreboard bench for popcount_stream (WIDTH=8, ACC_W=4 so saturation is reachable).
module tb_popcount_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  typedef struct {
    int cnt;
    int sum;
    int sat;
    int last;
    int acc_cyc;
    bit lat;
  } exp_t;

  exp_t exp_q[$];

  popcount_stream_if #(.WIDTH(8), .ACC_W(4)) bus ();

  popcount_stream #(.WIDTH(8), .ACC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a word from posedge+1 and hold it until accepted; push its expected result.
  task automatic send(input logic [7:0] d, input logic l, input int c, input int s,
                      input int st, input bit lat);
    bit acc = 1'b0;
    int n   = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{cnt: c, sum: s, sat: st, last: int'(l), acc_cyc: cyc, lat: lat});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout: word %0h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output transfer pops and compares one expected beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_beat: count %0d sum %0d with nothing expected",
                   bus.out_count, bus.out_sum);
        end else begin
          e = exp_q.pop_front();
          check("out_count",  int'(bus.out_count), e.cnt);
          check("out_onehot", int'(bus.out_onehot), 1 << e.cnt);
          check("out_sum",    int'(bus.out_sum), e.sum);
          check("out_sat",    int'(bus.out_sat), e.sat);
          check("out_last",   int'(bus.out_last), e.last);
          if (e.lat) check("latency", cyc - e.acc_cyc, 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid",  int'(bus.out_valid), 0);
    check("rst_out_count",  int'(bus.out_count), 0);
    check("rst_out_onehot", int'(bus.out_onehot), 0);
    check("rst_out_sum",    int'(bus.out_sum), 0);
    check("rst_out_sat",    int'(bus.out_sat), 0);
    check("rst_out_last",   int'(bus.out_last), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream: two beats in flight are discarded, frame restarts.
    bus.out_ready = 1'b0;
    send(8'h0F, 1'b0, 4, 4, 0, 1'b0);
    send(8'h0F, 1'b0, 4, 8, 0, 1'b0);
    idle(0);
    @(negedge clk);
    check("pre_rst_out_valid", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid",  int'(bus.out_valid), 0);
    check("midrst_out_count",  int'(bus.out_count), 0);
    check("midrst_out_onehot", int'(bus.out_onehot), 0);
    check("midrst_out_sum",    int'(bus.out_sum), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'hFF, 1'b1, 8, 8, 0, 1'b1);
    idle(4);

    // Back-to-back stream with a frame boundary after the third word.
    send(8'h01, 1'b0, 1, 1, 0, 1'b1);
    send(8'h03, 1'b0, 2, 3, 0, 1'b1);
    send(8'h07, 1'b1, 3, 6, 0, 1'b1);
    send(8'h0F, 1'b0, 4, 4, 0, 1'b1);
    idle(4);

    // Backpressure: frame continues from 4; downstream stalls while words keep coming.
    fork
      begin
        send(8'h11, 1'b0, 2, 6, 0, 1'b0);
        send(8'h30, 1'b0, 2, 8, 0, 1'b0);
        send(8'h01, 1'b0, 1, 9, 0, 1'b0);
        send(8'h80, 1'b1, 1, 10, 0, 1'b0);
        idle(0);
      end
      begin
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready",  int'(bus.in_ready), 0);
          check("stall_out_valid", int'(bus.out_valid), 1);
          check("stall_out_count", int'(bus.out_count), 2);
          check("stall_out_sum",   int'(bus.out_sum), 6);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(4);

    // Saturation at 15, sticky within the frame, cleared by the next frame.
    send(8'hFF, 1'b0, 8, 8,  0, 1'b1);
    send(8'hFF, 1'b0, 8, 15, 1, 1'b1);
    send(8'hFF, 1'b0, 8, 15, 1, 1'b1);
    send(8'hFF, 1'b0, 8, 15, 1, 1'b1);
    send(8'hFF, 1'b0, 8, 15, 1, 1'b1);
    send(8'hFF, 1'b1, 8, 15, 1, 1'b1);
    send(8'h03, 1'b1, 2, 2,  0, 1'b1);
    idle(4);

    // Zero word, then a bubble that must not disturb the frame sum.
    send(8'h00, 1'b0, 0, 0, 0, 1'b1);
    idle(4);
    @(negedge clk);
    check("bubble_out_valid",  int'(bus.out_valid), 0);
    check("bubble_out_sum",    int'(bus.out_sum), 0);
    check("bubble_out_onehot", int'(bus.out_onehot), 1);
    @(posedge clk);
    #1;
    send(8'h05, 1'b1, 2, 2, 0, 1'b1);
    idle(4);

    // clr with two beats in flight; a word offered during clr is refused.
    bus.out_ready = 1'b0;
    send(8'h0F, 1'b0, 4, 4, 0, 1'b0);
    send(8'h03, 1'b0, 2, 6, 0, 1'b0);
    bus.in_data   = 8'hFF;
    bus.in_last   = 1'b0;
    clr           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("clr_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("clr_out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    send(8'h07, 1'b1, 3, 3, 0, 1'b1);
    idle(6);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
